// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the data-memory port arbiter.
// The master side drives requests and BRAM read data; the slave side is the arbiter.
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [31:0]           addr0;
  logic [31:0]           addr1;
  logic [2:0]            f3_0;
  logic [2:0]            f3_1;
  logic [31:0]           wdata0;
  logic [31:0]           wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rsp_valid0;
  logic                  rsp_valid1;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, f3_0, f3_1, wdata0, wdata1,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, f3_0, f3_1, wdata0, wdata1,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin share of one data BRAM between two requesters; grant in IDLE, BRAM op one cycle later,
// response the cycle after that (one op per 3 cycles); requesters hold req until their grant pulse.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic last_gnt_q;
  logic port_q;
  logic we_q;
  logic err_q;

  logic                  take;
  logic                  sel;
  logic                  s_we;
  logic [31:0]           s_addr;
  logic [2:0]            s_f3;
  logic [31:0]           s_wdata;
  logic                  s_err;
  logic [3:0]            s_be;
  logic [31:0]           s_lanes;
  logic                  mem_en_d;
  logic [3:0]            mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_wdata_d;
  logic                  in_resp;

  // BU/HU are load-only; H needs halfword alignment, W needs word alignment.
  function automatic logic check_err(input logic we, input logic [1:0] off, input logic [2:0] f3);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = off[0];
      3'b010:  e = (off != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    sel         = 1'b0;
    s_we        = 1'b0;
    s_addr      = '0;
    s_f3        = '0;
    s_wdata     = '0;
    s_err       = 1'b0;
    s_be        = 4'b0000;
    s_lanes     = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (!rst && (bus.req0 || bus.req1)) begin
          take    = 1'b1;
          sel     = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    s_we    = sel ? bus.we1    : bus.we0;
    s_addr  = sel ? bus.addr1  : bus.addr0;
    s_f3    = sel ? bus.f3_1   : bus.f3_0;
    s_wdata = sel ? bus.wdata1 : bus.wdata0;
    s_err   = check_err(s_we, s_addr[1:0], s_f3);

    case (s_f3[1:0])
      2'b00: begin
        s_be    = 4'b0001 << s_addr[1:0];
        s_lanes = {4{s_wdata[7:0]}};
      end
      2'b01: begin
        s_be    = 4'b0011 << s_addr[1:0];
        s_lanes = {2{s_wdata[15:0]}};
      end
      default: begin
        s_be    = 4'b1111;
        s_lanes = s_wdata;
      end
    endcase

    if (take && !s_err) begin
      mem_en_d   = 1'b1;
      mem_addr_d = s_addr[ADDR_WIDTH+1:2];
      if (s_we) begin
        mem_we_d    = s_be;
        mem_wdata_d = s_lanes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_gnt_q    <= 1'b1;
      port_q        <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 4'b0000;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state_q       <= state_d;
      bus.mem_en    <= mem_en_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
      if (take) begin
        last_gnt_q <= sel;
        port_q     <= sel;
        we_q       <= s_we;
        err_q      <= s_err;
      end
    end
  end

  // A reset landing in RESP suppresses the response pulse.
  assign in_resp        = (state_q == S_RESP) && !rst;
  assign bus.gnt0       = take & ~sel;
  assign bus.gnt1       = take & sel;
  assign bus.rsp_valid0 = in_resp & ~port_q;
  assign bus.rsp_valid1 = in_resp & port_q;
  assign bus.rsp_err    = in_resp & err_q;
  assign bus.rsp_rdata  = (in_resp && !err_q && !we_q) ? bus.mem_rdata : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_addr[31:ADDR_WIDTH+2]};

endmodule
